// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the MEM-stage data-memory bus master.
// Holds the RV32I load/store width codes, the FSM encoding and the default timeout.
package mem_bus_master_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store legality/select/replication from the
// live MEM-stage request, load extraction and extension from the registered request.
module mem_lane_align
  import mem_bus_master_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic        st_we_i,
  input  logic [31:0] st_wdata_i,
  output logic        legal_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    legal_o = 1'b0;
    case (st_funct3_i)
      F3_B:    legal_o = 1'b1;
      F3_H:    legal_o = ~st_off_i[0];
      F3_W:    legal_o = (st_off_i == 2'b00);
      F3_BU:   legal_o = ~st_we_i;
      F3_HU:   legal_o = ~st_we_i & ~st_off_i[0];
      default: legal_o = 1'b0;
    endcase
  end

  // Loads always fetch the full word; the lane is picked out on return.
  always_comb begin
    sel_o   = 4'b1111;
    wdata_o = st_wdata_i;
    if (st_we_i) begin
      case (st_funct3_i[1:0])
        2'b00: begin
          sel_o   = 4'b0001 << st_off_i;
          wdata_o = {4{st_wdata_i[7:0]}};
        end
        2'b01: begin
          sel_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{st_wdata_i[15:0]}};
        end
        default: begin
          sel_o   = 4'b1111;
          wdata_o = st_wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    shifted   = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_byte   = shifted[7:0];
    ld_half   = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'd0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'd0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// MEM-stage load/store unit: issues one req/ack transaction on the data bus per
// legal access, stalls the pipeline until it finishes, and returns aligned load data.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall_mem,
  output logic [31:0] Datai,
  output logic        access_fault,
  output logic        bus_timeout,
  output logic        bus_cyc,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, datai_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        legal;
  logic [3:0]  sel_w;
  logic [31:0] wrep_w, ld_w;
  logic        issue, timeout_hit;

  mem_lane_align u_align (
    .st_funct3_i (funct3),
    .st_off_i    (addr[1:0]),
    .st_we_i     (mem_we),
    .st_wdata_i  (wdata),
    .legal_o     (legal),
    .sel_o       (sel_w),
    .wdata_o     (wrep_w),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (bus_rdata),
    .ld_data_o   (ld_w)
  );

  assign issue       = (state_q == ST_IDLE) && mem_req && legal;
  // Ack in the final allowed cycle still completes the access normally.
  assign timeout_hit = (state_q == ST_BUS) && (cnt_q == 8'(TIMEOUT_CYCLES - 1)) && !bus_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue) state_d = ST_BUS;
      ST_BUS:  if (bus_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_cyc      = (state_q == ST_BUS);
    stall_mem    = ~rst & mem_req & legal & (state_q != ST_DONE);
    access_fault = ~rst & (state_q == ST_IDLE) & mem_req & ~legal;
    bus_timeout  = timeout_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      datai_q <= 32'd0;
    end else if (issue) begin
      cnt_q   <= 8'd0;
      addr_q  <= {addr[31:2], 2'b00};
      wdata_q <= wrep_w;
      sel_q   <= sel_w;
      we_q    <= mem_we;
      f3_q    <= funct3;
      off_q   <= addr[1:0];
    end else if (state_q == ST_BUS) begin
      cnt_q <= cnt_q + 8'd1;
      if (bus_ack)          datai_q <= we_q ? 32'd0 : ld_w;
      else if (timeout_hit) datai_q <= 32'd0;
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_sel   = sel_q;
  assign bus_we    = we_q;
  assign Datai     = datai_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: loads, stores, faults, timeout and async reset.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall_mem;
  logic [31:0] Datai;
  logic        access_fault, bus_timeout, bus_cyc, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;

  int total = 0;
  int bad   = 0;

  mem_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall_mem(stall_mem), .Datai(Datai),
    .access_fault(access_fault), .bus_timeout(bus_timeout), .bus_cyc(bus_cyc),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one access and steps until the bus cycle ends; returns at the DONE cycle.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                      output int ncyc, output int nstall, output logic [31:0] o_addr,
                      output logic [31:0] o_wdata, output logic [3:0] o_sel,
                      output logic o_we, output logic saw_to);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    bus_rdata = rd; bus_ack = 1'b0;
    #1;
    nstall = int'(stall_mem); ncyc = 0; saw_to = 1'b0;
    o_addr = '0; o_wdata = '0; o_sel = '0; o_we = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      if (!bus_cyc) break;
      ncyc++;
      nstall += int'(stall_mem);
      if (ncyc == 1) begin
        o_addr = bus_addr; o_wdata = bus_wdata; o_sel = bus_sel; o_we = bus_we;
      end
      if (ncyc == ack_at) bus_ack = 1'b1;
      #1;
      saw_to |= bus_timeout;
      if (i == 399) ncyc = -1;
    end
  endtask

  task automatic retire();
    mem_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic fault(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] prev, input string tag);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = 32'h1111_2222;
    #1;
    chk({tag, "_fault"}, 32'(access_fault), 32'd1);
    chk({tag, "_stall"}, 32'(stall_mem), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    chk({tag, "_cyc"}, 32'(bus_cyc), 32'd0);
    chk({tag, "_datai"}, Datai, prev);
  endtask

  int          nc, ns;
  logic [31:0] oa, ow;
  logic [3:0]  osel;
  logic        owe, sto;

  initial begin
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'd0; addr = '0;
    wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    #2;
    chk("rst_cyc", 32'(bus_cyc), 32'd0);
    chk("rst_stall", 32'(stall_mem), 32'd0);
    chk("rst_datai", Datai, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // LB sign-extended from byte 3
    xact(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, nc, ns, oa, ow, osel, owe, sto);
    chk("lb_ncyc", 32'(nc), 32'd1);
    chk("lb_addr", oa, 32'h0000_1000);
    chk("lb_sel", 32'(osel), 32'hF);
    chk("lb_we", 32'(owe), 32'd0);
    chk("lb_stall_hi", 32'(ns), 32'd2);
    chk("lb_stall_done", 32'(stall_mem), 32'd0);
    chk("lb_datai", Datai, 32'hFFFF_FF80);
    retire();

    xact(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hABCD_0011, 1, nc, ns, oa, ow, osel, owe, sto);
    chk("lhu_datai", Datai, 32'h0000_ABCD);
    retire();

    xact(1'b1, 3'b001, 32'h0000_3002, 32'h1234_5678, 32'hFFFF_FFFF, 1, nc, ns, oa, ow, osel, owe, sto);
    chk("sh_sel", 32'(osel), 32'hC);
    chk("sh_wdata", ow, 32'h5678_5678);
    chk("sh_we", 32'(owe), 32'd1);
    chk("sh_datai", Datai, 32'd0);
    retire();

    xact(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0, 1, nc, ns, oa, ow, osel, owe, sto);
    chk("sb_sel", 32'(osel), 32'h2);
    chk("sb_wdata", ow, 32'hABAB_ABAB);
    chk("sb_addr", oa, 32'h0000_0100);
    retire();

    xact(1'b0, 3'b001, 32'h0000_0200, 32'h0, 32'h0000_8001, 1, nc, ns, oa, ow, osel, owe, sto);
    chk("lh_datai", Datai, 32'hFFFF_8001);
    retire();

    xact(1'b0, 3'b100, 32'h0000_0301, 32'h0, 32'h0000_F500, 2, nc, ns, oa, ow, osel, owe, sto);
    chk("lbu_ncyc", 32'(nc), 32'd2);
    chk("lbu_datai", Datai, 32'h0000_00F5);
    retire();

    xact(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, nc, ns, oa, ow, osel, owe, sto);
    chk("lw_datai", Datai, 32'hDEAD_BEEF);
    retire();

    fault(1'b0, 3'b010, 32'h0000_4001, 32'hDEAD_BEEF, "lw_mis");
    fault(1'b0, 3'b011, 32'h0000_4000, 32'hDEAD_BEEF, "f3_011");
    fault(1'b1, 3'b100, 32'h0000_4000, 32'hDEAD_BEEF, "sbu");
    fault(1'b0, 3'b001, 32'h0000_4003, 32'hDEAD_BEEF, "lh_mis");

    // ack arriving in the last allowed cycle beats the timeout
    xact(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 4, nc, ns, oa, ow, osel, owe, sto);
    chk("late_ncyc", 32'(nc), 32'd4);
    chk("late_to", 32'(sto), 32'd0);
    chk("late_datai", Datai, 32'h0BAD_F00D);
    retire();

    xact(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h5555_5555, 0, nc, ns, oa, ow, osel, owe, sto);
    chk("to_ncyc", 32'(nc), 32'd4);
    chk("to_pulse", 32'(sto), 32'd1);
    chk("to_datai", Datai, 32'd0);
    chk("to_stall", 32'(stall_mem), 32'd0);
    retire();

    xact(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 2, nc, ns, oa, ow, osel, owe, sto);
    chk("sw_ncyc", 32'(nc), 32'd2);
    chk("sw_sel", 32'(osel), 32'hF);
    chk("sw_wdata", ow, 32'hCAFE_F00D);
    chk("sw_addr", oa, 32'h0000_0040);
    retire();

    xact(1'b0, 3'b010, 32'h0000_0060, 32'h0, 32'h1357_9BDF, 1, nc, ns, oa, ow, osel, owe, sto);
    chk("pre_rst_datai", Datai, 32'h1357_9BDF);
    retire();

    // async reset in the middle of a bus cycle
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0070; bus_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_cyc", 32'(bus_cyc), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cyc", 32'(bus_cyc), 32'd0);
    chk("mid_rst_stall", 32'(stall_mem), 32'd0);
    chk("mid_rst_datai", Datai, 32'd0);
    @(negedge clk);
    mem_req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post_rst_cyc", 32'(bus_cyc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- MEM-stage data-memory access unit for the 5-stage pipeline; the producer side of the MEM/WB load-data path.
- Takes the MEM-stage load/store request and runs a req/ack transaction on the MIO data bus.
- Aligns store data and byte-lane selects; aligns and sign/zero-extends load data into Datai for the MEM/WB latch.
- Drives a stall to hold the pipeline until the bus transaction completes or times out.

Parameters:
- TIMEOUT_CYCLES, 255, number of BUS-state cycles without ack before the transaction is abandoned (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_req  in  1  valid load/store in the MEM stage
- mem_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code
- addr  in  32  effective address (ALU output)
- wdata  in  32  store data (rs2)
- stall_mem  out  1  hold IF..MEM; MEM/WB EN = ~stall_mem
- Datai  out  32  aligned/extended load data to MEM/WB
- access_fault  out  1  1-cycle pulse: misaligned or illegal funct3
- bus_timeout  out  1  1-cycle pulse: ack never arrived
- bus_cyc  out  1  bus request, held until ack or timeout
- bus_we  out  1  bus write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_sel  out  4  byte-lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  bus read data
- bus_ack  in  1  bus completion, sampled in BUS state only

Behaviour:
- Reset: state IDLE; all outputs 0; counter 0. Asserting rst mid-transaction drops bus_cyc immediately.
- States: IDLE, BUS, DONE.
- IDLE, mem_req=1, legal access: register bus_addr, bus_we, bus_sel, bus_wdata; go to BUS.
- IDLE, mem_req=1, illegal access (see legality below): pulse access_fault; no bus cycle; stay in IDLE; stall_mem=0; Datai unchanged.
- BUS: bus_cyc=1; address, data and select held stable; counter increments each cycle.
- BUS, bus_ack=1: capture the extracted load data (0 for stores) into Datai; clear bus_cyc; go to DONE.
- BUS, counter reaches TIMEOUT_CYCLES-1 with no ack: clear bus_cyc; pulse bus_timeout; Datai=0; go to DONE.
- If ack and timeout occur in the same cycle, ack wins.
- DONE: stall_mem=0 for exactly 1 cycle; return to IDLE. The next IDLE cycle sees the next instruction, so there is no re-issue.
- stall_mem = mem_req & legal & (state != DONE), combinational.
- Latency with ack in the first BUS cycle: 3 MEM cycles (issue, BUS, DONE). Datai is valid in DONE and held until the next completion.
- Legality:
  - funct3 000 (byte): any address.
  - funct3 001/101 (half): addr[0] must be 0.
  - funct3 010 (word): addr[1:0] must be 00.
  - funct3 011, 110, 111: always illegal.
  - funct3 100/101 with mem_we=1: illegal.
- Store lanes:
  - SB: sel = 0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: sel = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - SW: sel = 1111; wdata unchanged.
- Load lanes: bus_sel = 1111.
  - LB/LBU: byte = rdata >> (8*addr[1:0]).
  - LH/LHU: half = addr[1] ? rdata[31:16] : rdata[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Extraction uses the registered addr[1:0] and funct3 captured at issue, not the live inputs.
- mem_req deasserting while in BUS (e.g. flush): the transaction still completes; bus protocol integrity takes priority.

Decomposition:
- Shared package holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding;
  - default TIMEOUT_CYCLES.
- One sub-module, mem_lane_align, is natural: purely combinational; store sel/data generation and load extraction/extension.

Test Plan:
- Reset: rst=1 pulsed while bus_cyc=1 in BUS -> bus_cyc=0, stall_mem=0, Datai=0, state IDLE immediately.
- LB: addr=0x1003, rdata=0x80FF_1234, ack in first BUS cycle -> bus_addr=0x1000, sel=1111, Datai=0xFFFF_FF80, stall_mem high 2 cycles then low 1.
- LHU: addr=0x2002, rdata=0xABCD_0011 -> Datai=0x0000_ABCD.
- SH: addr=0x3002, wdata=0x1234_5678 -> sel=1100, bus_wdata=0x5678_5678, bus_we=1; Datai=0 in DONE.
- Faults:
  - LW at addr=0x4001 -> access_fault pulse, bus_cyc never asserted, stall_mem=0.
  - funct3=011 -> same response.
- Timeout: TIMEOUT_CYCLES=4, ack held 0 -> bus_cyc high 4 cycles, bus_timeout pulse, Datai=0, DONE, then a subsequent SW completes normally.
